instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/instruction width.
REQ-002 SHALL have parameter DEPTH, default 4, instruction buffer entries (power of 2, >=2).
REQ-003 SHALL have parameter MAX_OUT, default 2, maximum outstanding memory requests (1..DEPTH).
REQ-004 SHALL have parameter RESET_PC, default 0, first fetch address.
REQ-005 SHALL use one clock; reset is synchronous and active-low.
REQ-006 SHALL have ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  word-aligned fetch address
- imem_rsp_valid  in  1  in-order response valid, always accepted
- imem_rsp_data  in  XLEN  instruction word
- redirect_valid  in  1  branch/jump taken, flush and refetch
- redirect_pc  in  XLEN  new fetch address, bits [1:0] ignored
- halt  in  1  suppress new requests
- instr_valid  out  1  buffered instruction available to decode
- instr_ready  in  1  decode accepts (low = stall)
- instr_data  out  XLEN  instruction at buffer head
- instr_pc  out  XLEN  address of instr_data
- outstanding  out  $clog2(MAX_OUT+1)  in-flight request count (debug)

Function
REQ-007 SHALL hold fetch PC register; request handshake = imem_req_valid & imem_req_ready; on handshake fetch PC SHALL advance by 4 next cycle.
REQ-008 SHALL drive imem_req_valid = !halt & !redirect_valid & (outstanding < MAX_OUT) & (occupancy + outstanding < DEPTH) (credit rule, buffer never overflows).
REQ-009 SHALL keep imem_req_addr stable while imem_req_valid high and not accepted.
REQ-010 SHALL record each accepted request's PC in a MAX_OUT-entry in-order PC queue; on a non-dropped response, SHALL push {PC, data} into the buffer.
REQ-011 SHALL present buffer head registered: instr_valid earliest one cycle after the response cycle; pop on instr_valid & instr_ready.
REQ-012 SHALL support simultaneous push and pop in one cycle, including at full.
REQ-013 On redirect_valid, SHALL: empty buffer and PC queue next cycle; load fetch PC with {redirect_pc[XLEN-1:2],2'b00}; set drop counter to outstanding requests (incl. any accepted or not-yet-responded that cycle, minus a response arriving that cycle).
REQ-014 While drop counter > 0, each response SHALL be discarded and the counter decremented; no push.
REQ-015 A response arriving in the redirect cycle SHALL be discarded.
REQ-016 A pop handshake in the redirect cycle SHALL complete (decode owns that instruction); remaining entries discarded.
REQ-017 A redirect while drop counter > 0 SHALL add the new in-flight count to the existing drop count.
REQ-018 First request after redirect SHALL occur no earlier than the cycle after redirect_valid.
REQ-019 halt SHALL block new requests only; in-flight responses still buffered, buffer still drains.
REQ-020 Buffer pointers SHALL wrap modulo DEPTH; full/empty from an occupancy counter of width $clog2(DEPTH+1).
REQ-021 Fetch PC SHALL wrap modulo 2^XLEN without error.

Reset
REQ-022 With rst low at clk edge: fetch PC = RESET_PC, buffer and PC queue empty, outstanding = 0, drop counter = 0.
REQ-023 During reset imem_req_valid = 0 and instr_valid = 0; responses arriving during reset SHALL be ignored.
REQ-024 Reset mid-operation SHALL discard all state; memory is required to be reset on the same rst.
REQ-025 First request (addr RESET_PC) SHALL be driven in the first cycle rst is high.

Structure
REQ-026 Shared package cpu_pkg SHALL hold XLEN, RESET_PC default, and the fetch entry struct {pc, instr}.
REQ-027 Buffer SHALL be one sub-module fetch_fifo (parametrised width/depth, synchronous flush); PC queue may reuse it.

Verification
REQ-028 Reset, 1-cycle memory, instr_ready=1: instr_pc sequence 0,4,8,12 on consecutive cycles, first instr_valid 2 cycles after first request.
REQ-029 instr_ready=0 for 10 cycles, DEPTH=4: exactly 4 entries buffered, imem_req_valid low thereafter, no data lost after release.
REQ-030 Redirect to 0x103 with 2 outstanding, 3-cycle memory: both stale responses dropped, next instr_pc = 0x100.
REQ-031 Redirect coincident with response and pop: popped entry delivered once, response dropped, buffer empty next cycle.
REQ-032 halt=1 with 2 in flight: no new requests, both responses delivered, outstanding reaches 0.
REQ-033 Random imem_req_ready/latency/instr_ready/redirect, 10k cycles: scoreboard confirms in-order, no duplicates, no stale instructions.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-path widths, reset address and the buffered fetch entry layout.
package cpu_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = '0;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: register-array FIFO with synchronous flush, simultaneous push/pop and occupancy count.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    // explicit wrap keeps non-power-of-2 depths (the PC queue) correct
    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction
    assign do_pop   = pop & (count != '0);
    assign do_push  = push & ((count < CW'(DEPTH)) | do_pop);
    assign pop_data = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= inc(wr_ptr);
            end
            if (do_pop) rd_ptr <= inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: credit-limited instruction fetch with in-order PC queue, instruction buffer and redirect flush.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int XLEN = cpu_pkg::XLEN,
    parameter int DEPTH = 4,
    parameter int MAX_OUT = 2,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(cpu_pkg::RESET_PC)
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         imem_req_valid,
    input  logic                         imem_req_ready,
    output logic [XLEN-1:0]              imem_req_addr,
    input  logic                         imem_rsp_valid,
    input  logic [XLEN-1:0]              imem_rsp_data,
    input  logic                         redirect_valid,
    input  logic [XLEN-1:0]              redirect_pc,
    input  logic                         halt,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    output logic [XLEN-1:0]              instr_data,
    output logic [XLEN-1:0]              instr_pc,
    output logic [$clog2(MAX_OUT+1)-1:0] outstanding
);
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int BW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(DEPTH + MAX_OUT + 1);
    logic [XLEN-1:0]   fetch_pc, pcq_head;
    logic [2*XLEN-1:0] head;
    logic [OW-1:0]     out_cnt, out_next, drop_cnt, pcq_cnt;
    logic [BW-1:0]     occ;
    logic              req_hs, rsp_live, rsp_keep;
    // outstanding requests reserve buffer slots so a response always has room
    assign imem_req_valid = rst & ~halt & ~redirect_valid & (out_cnt < OW'(MAX_OUT))
                          & (SW'(occ) + SW'(out_cnt) < SW'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_hs         = imem_req_valid & imem_req_ready;
    assign rsp_live       = imem_rsp_valid & (drop_cnt == '0);
    assign rsp_keep       = rsp_live & ~redirect_valid & (pcq_cnt != '0);
    assign out_next       = out_cnt + OW'(req_hs) - OW'(imem_rsp_valid);
    assign outstanding    = out_cnt;
    assign instr_valid    = rst & (occ != '0);
    assign instr_pc       = head[2*XLEN-1:XLEN];
    assign instr_data     = head[XLEN-1:0];
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            out_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            out_cnt <= out_next;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc & ~XLEN'(3);
                drop_cnt <= out_next;
            end else begin
                if (req_hs) fetch_pc <= fetch_pc + XLEN'(4);
                if (imem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end
    fetch_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUT)) pcq (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (req_hs),
        .push_data (fetch_pc),
        .pop       (rsp_live),
        .pop_data  (pcq_head),
        .count     (pcq_cnt)
    );
    fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) ibuf (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (rsp_keep),
        .push_data ({pcq_head, imem_rsp_data}),
        .pop       (instr_valid & instr_ready),
        .pop_data  (head),
        .count     (occ)
    );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed plus random fetch scenarios with an in-order memory model and PC scoreboard.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        instr_valid, instr_ready;
    logic [31:0] instr_data, instr_pc;
    logic [1:0]  outstanding;

    instr_fetch_unit #(.XLEN(32), .DEPTH(4), .MAX_OUT(2), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .outstanding    (outstanding)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0, last_due = 0, lat_lo = 1, lat_hi = 1, n;
    logic [31:0] mem_q[$];
    int          mem_due[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_fetch = '0;
    logic        s_rv, s_iv;
    logic [31:0] s_ra, s_ipc, s_id;
    logic [1:0]  s_out;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [31:0] e, ed;
        int due;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (rst && mem_q.size() != 0 && mem_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = ~mem_q[0];
        end
        @(negedge clk);
        s_rv = imem_req_valid; s_ra = imem_req_addr; s_iv = instr_valid;
        s_ipc = instr_pc; s_id = instr_data; s_out = outstanding;
        if (!rst) begin
            chk("reset_req_valid", s_rv, 0);
            chk("reset_instr_valid", s_iv, 0);
            mem_q.delete(); mem_due.delete(); exp_q.delete();
            exp_fetch = '0;
            last_due = 0;
        end else begin
            chk("outstanding", s_out, mem_q.size());
            if (redirect_valid) chk("req_in_redirect", s_rv, 0);
            if (s_rv) chk("req_addr", s_ra, exp_fetch);
            if (s_rv && imem_req_ready) begin
                due = cyc + $urandom_range(lat_hi, lat_lo);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mem_q.push_back(s_ra);
                mem_due.push_back(due);
                exp_q.push_back(s_ra);
                exp_fetch += 32'd4;
            end
            if (s_iv && instr_ready) begin
                if (exp_q.size() == 0) chk("spurious_instr_valid", s_iv, 0);
                else begin
                    e  = exp_q.pop_front();
                    ed = ~e;
                    chk("instr_pc", s_ipc, e);
                    chk("instr_data", s_id, ed);
                end
            end
            if (imem_rsp_valid) begin
                void'(mem_q.pop_front());
                void'(mem_due.pop_front());
            end
            if (redirect_valid) begin
                exp_q.delete();
                exp_fetch = redirect_pc & ~32'h3;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_iv(input string tag, input logic [31:0] pc);
        bit got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            tick();
            if (s_iv && instr_ready) begin
                got = 1;
                chk(tag, s_ipc, pc);
            end
        end
        if (!got) chk({tag, "_timeout"}, s_iv, 1);
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0; instr_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b1; imem_req_ready = 1'b1; instr_ready = 1'b1;
        tick();
        chk("first_req_valid", s_rv, 1);
        chk("first_req_addr", s_ra, 0);
        tick();
        chk("first_iv_early", s_iv, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("seq_valid", s_iv, 1);
            chk("seq_pc", s_ipc, 32'(i * 4));
        end
        instr_ready = 1'b0;
        repeat (10) tick();
        chk("stall_req_low", s_rv, 0);
        chk("stall_outstanding", s_out, 0);
        halt = 1'b1; instr_ready = 1'b1; n = 0;
        repeat (8) begin
            tick();
            if (s_iv) n++;
        end
        chk("stall_buffered", n, 4);
        halt = 1'b0;
        lat_lo = 3; lat_hi = 3;
        repeat (6) tick();
        for (int i = 0; i < 20 && outstanding != 2; i++) tick();
        chk("pre_redirect_outstanding", outstanding, 2);
        redirect_to(32'h103);
        wait_iv("redirect_first_pc", 32'h100);
        lat_lo = 1; lat_hi = 1;
        repeat (6) tick();
        for (int i = 0; i < 20 && !(instr_valid && mem_q.size() != 0 && mem_due[0] <= cyc); i++) tick();
        redirect_to(32'h200);
        chk("redir_pop_valid", s_iv, 1);
        tick();
        chk("redir_buffer_empty", s_iv, 0);
        wait_iv("redir_target", 32'h200);
        redirect_to(32'hFFFF_FFF9);
        wait_iv("wrap_first", 32'hFFFF_FFF8);
        wait_iv("wrap_next", 32'hFFFF_FFFC);
        wait_iv("wrap_zero", 32'h0);
        lat_lo = 3; lat_hi = 3;
        repeat (6) tick();
        for (int i = 0; i < 20 && outstanding != 2; i++) tick();
        halt = 1'b1;
        repeat (12) begin
            tick();
            chk("halt_no_req", s_rv, 0);
        end
        chk("halt_outstanding", s_out, 0);
        chk("halt_all_delivered", exp_q.size(), 0);
        halt = 1'b0;
        lat_lo = 1; lat_hi = 2;
        repeat (5) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("post_reset_req", s_rv, 1);
        chk("post_reset_addr", s_ra, 0);
        lat_lo = 1; lat_hi = 4;
        repeat (10000) begin
            rst            = ($urandom_range(999, 0) != 0);
            imem_req_ready = ($urandom_range(3, 0) != 0);
            instr_ready    = ($urandom_range(3, 0) != 0);
            halt           = ($urandom_range(19, 0) == 0);
            redirect_valid = ($urandom_range(29, 0) == 0);
            redirect_pc    = $urandom;
            tick();
        end
        rst = 1'b1; redirect_valid = 1'b0; halt = 1'b1; instr_ready = 1'b1;
        repeat (20) tick();
        chk("drain_outstanding", s_out, 0);
        chk("drain_instr_valid", s_iv, 0);
        chk("drain_all_delivered", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
